uop_issue_queue: RTL and testbench
==================================

// Module: uop_issue_queue
// PURPOSE
//  Buffers uop bundles from microcode_unit and issues them one slot per cycle to the decode/rename stage.
//  A bundle carries two 36-bit slots. It is accepted whole or not at all.
//  Speculative slots are squashed by branch tag on a mispredict.
//  Slots are also cleared by a full pipeline flush.
// PARAMETERS
//  DEPTH                   8   slot entries, power of two, >= 2
//  SLOT_WIDTH              36  bits per slot: [35:4] instr, [3:2] branch tag, [1] valid, [0] spec
//  MAX_PREDICT_DEPTH_BITS  2   branch tag width, taken from defines.inc
//  UOP_BUF_WIDTH           72  bundle width = 2*SLOT_WIDTH, taken from defines.inc
// PORTS
//  clk        in   1                       single clock; all state updates on posedge
//  reset      in   1                       synchronous, active-high
//  in_bundle  in   UOP_BUF_WIDTH           [71:36] older slot, [35:0] younger slot
//  in_valid   in   1                       in_bundle is presented
//  in_ready   out  1                       queue accepts the bundle this cycle
//  out_instr  out  32                      instruction of the head slot
//  out_tag    out  MAX_PREDICT_DEPTH_BITS  branch tag of the head slot
//  out_spec   out  1                       speculative flag of the head slot
//  out_valid  out  1                       a live head slot is presented
//  out_ready  in   1                       consumer takes the head slot
//  kill_valid in   1                       mispredict squash request
//  kill_tag   in   MAX_PREDICT_DEPTH_BITS  tag being squashed
//  flush      in   1                       discard all contents
//  count      out  $clog2(DEPTH)+1         occupied entries, dead entries included
// BEHAVIOUR
//  Reset and flush:
//   - State reset: count=0, head=tail=0, every entry dead.
//   - Output values: out_valid=0, out_instr/out_tag/out_spec=0, in_ready=1.
//   - reset and flush act identically and win over all other inputs in the same cycle.
//  Accept rule:
//   - in_ready = (DEPTH-count >= 2) && !flush, combinational from registered count.
//   - in_ready does not depend on out_ready; no full bypass.
//  Enqueue (in_valid && in_ready):
//   - The older slot is written at tail if its valid bit [1] is set.
//   - The younger slot is written at the next free entry if its valid bit is set.
//   - tail advances by 0, 1 or 2 and wraps mod DEPTH.
//   - A bundle with both slots invalid is accepted and has no effect.
//  Issue:
//   - out_valid = count!=0 && head entry live && !(kill hit on head this cycle).
//   - Dequeue happens on out_valid && out_ready; head advances by 1 and wraps mod DEPTH.
//   - Output fields are driven from the head entry, combinationally.
//  Latency:
//   - A slot enqueued on edge N is presented as the head from cycle N+1 at the earliest.
//   - There is no empty bypass.
//  Dead-slot drain:
//   - If the head entry is dead and count!=0, it is popped automatically.
//   - The pop happens at one entry per cycle, with out_valid=0.
//  Kill (kill_valid):
//   - Every stored entry with spec=1 and tag==kill_tag is marked dead on the same edge.
//   - Incoming slots accepted on that edge that match are also written dead.
//   - Non-spec entries and entries with other tags are untouched.
//   - A head entry that matches is not issued that cycle.
//  Simultaneous events:
//   - Enqueue and dequeue in the same cycle give count += n_enq-1.
//   - Kill together with enqueue and dequeue applies all three on one edge.
//  Order: slots are issued strictly in arrival order, the older slot before the younger one.
//  Invariants:
//   - count never exceeds DEPTH or drops below 0.
//   - Pointers are $clog2(DEPTH) bits; count==DEPTH means full.
// STRUCTURE
//  - defines.inc supplies UOP_BUF_WIDTH, MAX_PREDICT_DEPTH_BITS and the slot field offsets.
//  - instruction.sv gains a packed slot_t typedef {instr, tag, valid, spec}.
//  - Storage is a flat array of slot_t plus a per-entry live bit.
//  - There is no sub-module; the slot unpack function lives in the shared package.
// TESTING
//  1 Reset, then bundle {0x25270004,tag2,v,s | 0x25270005,tag2,v,s}:
//    - out shows 0x25270004 first, then 0x25270005.
//    - out_tag=2 and out_spec=1 for both.
//  2 Bundle with younger slot valid=0 (instr 0), out_ready=1:
//    - Exactly one issue occurs, 0x25270004.
//    - count returns to 0.
//  3 Hold out_ready=0 and push 4 full bundles, DEPTH=8:
//    - in_ready drops to 0 at count=8.
//    - Releasing out_ready drains 8 slots in order.
//  4 Fill with tag1 and tag2 spec slots, then pulse kill_valid with kill_tag=2:
//    - Only tag1 slots are issued.
//    - count reaches 0 after the dead entries drain.
//  5 Queue half full, assert flush together with in_valid:
//    - Next cycle count=0 and out_valid=0.
//    - The bundle is not accepted.
//  6 count=6, in_valid and out_ready together for 3 cycles:
//    - count stays at 6+1 per cycle until in_ready falls.
//    - No slot is lost or duplicated.

Source files
------------

// File: rtl/uop_issue_queue_pkg.sv
// Shared slot layout, bundle widths and slot helpers for the uop issue queue.
//   slot_t       : packed {instr, tag, valid, spec}, 36 bits
//   slot_unpack  : raw slot bits -> slot_t
//   kill_match   : slot is hit by a mispredict squash on the given tag
package uop_issue_queue_pkg;

  localparam int unsigned MAX_PREDICT_DEPTH_BITS = 2;
  localparam int unsigned INSTR_WIDTH            = 32;
  localparam int unsigned SLOT_WIDTH             = INSTR_WIDTH + MAX_PREDICT_DEPTH_BITS + 2;
  localparam int unsigned UOP_BUF_WIDTH          = 2 * SLOT_WIDTH;

  // Field offsets inside one slot.
  localparam int unsigned SLOT_SPEC_BIT   = 0;
  localparam int unsigned SLOT_VALID_BIT  = 1;
  localparam int unsigned SLOT_TAG_LSB    = 2;
  localparam int unsigned SLOT_INSTR_LSB  = SLOT_TAG_LSB + MAX_PREDICT_DEPTH_BITS;

  typedef logic [MAX_PREDICT_DEPTH_BITS-1:0] tag_t;

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] instr;
    tag_t                   tag;
    logic                   valid;
    logic                   spec;
  } slot_t;

  function automatic slot_t slot_unpack(input logic [SLOT_WIDTH-1:0] raw);
    return slot_t'(raw);
  endfunction

  function automatic logic kill_match(input slot_t s, input logic kv, input tag_t kt);
    return kv && s.spec && (s.tag == kt);
  endfunction

endpackage

// File: rtl/uop_issue_queue_if.sv
// Producer/consumer/control bundle of the uop issue queue.
//   slave  : queue side (takes bundles, presents head slot, obeys kill/flush)
//   master : environment side (microcode unit, decode stage, branch unit)
interface uop_issue_queue_if #(
  parameter int unsigned DEPTH = 8
);
  import uop_issue_queue_pkg::*;

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [UOP_BUF_WIDTH-1:0] in_bundle;
  logic                     in_valid;
  logic                     in_ready;
  logic [INSTR_WIDTH-1:0]   out_instr;
  tag_t                     out_tag;
  logic                     out_spec;
  logic                     out_valid;
  logic                     out_ready;
  logic                     kill_valid;
  tag_t                     kill_tag;
  logic                     flush;
  logic [CNT_W-1:0]         count;

  modport slave (
    input  in_bundle, in_valid, out_ready, kill_valid, kill_tag, flush,
    output in_ready, out_instr, out_tag, out_spec, out_valid, count
  );

  modport master (
    output in_bundle, in_valid, out_ready, kill_valid, kill_tag, flush,
    input  in_ready, out_instr, out_tag, out_spec, out_valid, count
  );

endinterface

// File: rtl/uop_issue_queue.sv
// Two-slot-wide in, one-slot-wide out circular queue of uops with
// branch-tag squash and full flush.
//   clk, reset : clock, synchronous active-high reset
//   bus        : uop_issue_queue_if.slave (bundle in, head slot out,
//                kill/flush control, occupancy count)
module uop_issue_queue #(
  parameter int unsigned DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  uop_issue_queue_if.slave   bus
);
  import uop_issue_queue_pkg::*;

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  slot_t            r_mem  [DEPTH];
  logic             r_live [DEPTH];
  logic [PTR_W-1:0] r_head;
  logic [PTR_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  slot_t            w_old;
  slot_t            w_yng;
  logic [CNT_W-1:0] w_free;
  logic             w_in_ready;
  logic             w_enq;
  logic             w_wr_old;
  logic             w_wr_yng;
  logic [PTR_W-1:0] w_yng_idx;
  logic [PTR_W-1:0] w_tail_nxt;
  logic             w_nonempty;
  logic             w_head_live;
  logic             w_head_hit;
  logic             w_out_valid;
  logic             w_pop;
  logic [CNT_W-1:0] w_count_nxt;

  // Accept, enqueue placement, issue and pop decisions.
  always_comb begin
    w_old       = slot_unpack(bus.in_bundle[UOP_BUF_WIDTH-1:SLOT_WIDTH]);
    w_yng       = slot_unpack(bus.in_bundle[SLOT_WIDTH-1:0]);
    w_free      = CNT_W'(DEPTH) - r_count;
    w_in_ready  = (w_free >= CNT_W'(2)) && !bus.flush;
    w_enq       = bus.in_valid && w_in_ready;
    w_wr_old    = w_enq && w_old.valid;
    w_wr_yng    = w_enq && w_yng.valid;
    // Younger slot packs behind the older one, or takes tail if older is empty.
    w_yng_idx   = r_tail + PTR_W'(w_wr_old);
    w_tail_nxt  = r_tail + PTR_W'(w_wr_old) + PTR_W'(w_wr_yng);

    w_nonempty  = (r_count != '0);
    w_head_live = r_live[r_head] && r_mem[r_head].valid;
    w_head_hit  = kill_match(r_mem[r_head], bus.kill_valid, bus.kill_tag);
    w_out_valid = w_nonempty && w_head_live && !w_head_hit;
    // Live head leaves on handshake; dead head is drained without handshake.
    w_pop       = (w_out_valid && bus.out_ready) || (w_nonempty && !w_head_live);
    w_count_nxt = r_count + CNT_W'(w_wr_old) + CNT_W'(w_wr_yng) - CNT_W'(w_pop);
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk) begin
    if (reset || bus.flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i]  <= '0;
        r_live[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (kill_match(r_mem[i], bus.kill_valid, bus.kill_tag)) begin
          r_live[i] <= 1'b0;
        end
      end
      if (w_pop) begin
        r_live[r_head] <= 1'b0;
      end
      // New slots land in free entries only, so these never collide with the pop.
      if (w_wr_old) begin
        r_mem[r_tail]  <= w_old;
        r_live[r_tail] <= !kill_match(w_old, bus.kill_valid, bus.kill_tag);
      end
      if (w_wr_yng) begin
        r_mem[w_yng_idx]  <= w_yng;
        r_live[w_yng_idx] <= !kill_match(w_yng, bus.kill_valid, bus.kill_tag);
      end
      r_head  <= r_head + PTR_W'(w_pop);
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Head fields read zero while the queue is empty.
  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_instr = w_nonempty ? r_mem[r_head].instr : '0;
  assign bus.out_tag   = w_nonempty ? r_mem[r_head].tag   : '0;
  assign bus.out_spec  = w_nonempty ? r_mem[r_head].spec  : 1'b0;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_uop_issue_queue.sv
// Directed bench for uop_issue_queue (DEPTH=8).
module tb_uop_issue_queue;
  import uop_issue_queue_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_err = 0;

  uop_issue_queue_if #(.DEPTH(8)) bus ();
  uop_issue_queue #(.DEPTH(8)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, required finish before limit");
    $fatal(1);
  end

  function automatic logic [SLOT_WIDTH-1:0] mk(input logic [31:0] instr, input logic [1:0] tag,
                                               input logic v, input logic s);
    return {instr, tag, v, s};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [UOP_BUF_WIDTH-1:0] b);
    bus.in_bundle = b;
    bus.in_valid  = 1'b1;
    tick();
    bus.in_valid  = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    #1;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL reset_count got %0d exp 0", bus.count); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
    n_vec++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL reset_out_instr got %h exp 0", bus.out_instr); end
    n_vec++; if (bus.out_tag !== 2'd0) begin n_err++; $display("FAIL reset_out_tag got %0d exp 0", bus.out_tag); end
    n_vec++; if (bus.out_spec !== 1'b0) begin n_err++; $display("FAIL reset_out_spec got %b exp 0", bus.out_spec); end
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
  endtask

  task automatic test_pair();
    bus.out_ready = 1'b0;
    bus.in_bundle = {mk(32'h25270004, 2'd2, 1'b1, 1'b1), mk(32'h25270005, 2'd2, 1'b1, 1'b1)};
    bus.in_valid  = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL pair_in_ready got %b exp 1", bus.in_ready); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL pair_no_bypass got %b exp 0", bus.out_valid); end
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.count !== 4'd2) begin n_err++; $display("FAIL pair_count got %0d exp 2", bus.count); end
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL pair_valid0 got %b exp 1", bus.out_valid); end
    n_vec++; if (bus.out_instr !== 32'h25270004) begin n_err++; $display("FAIL pair_instr0 got %h exp 25270004", bus.out_instr); end
    n_vec++; if (bus.out_tag !== 2'd2) begin n_err++; $display("FAIL pair_tag0 got %0d exp 2", bus.out_tag); end
    n_vec++; if (bus.out_spec !== 1'b1) begin n_err++; $display("FAIL pair_spec0 got %b exp 1", bus.out_spec); end
    bus.out_ready = 1'b1;
    tick();
    n_vec++; if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL pair_valid1 got %b exp 1", bus.out_valid); end
    n_vec++; if (bus.out_instr !== 32'h25270005) begin n_err++; $display("FAIL pair_instr1 got %h exp 25270005", bus.out_instr); end
    n_vec++; if (bus.out_tag !== 2'd2) begin n_err++; $display("FAIL pair_tag1 got %0d exp 2", bus.out_tag); end
    n_vec++; if (bus.out_spec !== 1'b1) begin n_err++; $display("FAIL pair_spec1 got %b exp 1", bus.out_spec); end
    tick();
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL pair_count_end got %0d exp 0", bus.count); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL pair_valid_end got %b exp 0", bus.out_valid); end
  endtask

  task automatic test_single_slot();
    int n_issue = 0;
    bus.out_ready = 1'b1;
    push({mk(32'h25270004, 2'd0, 1'b1, 1'b0), mk(32'h0, 2'd0, 1'b0, 1'b0)});
    n_vec++; if (bus.count !== 4'd1) begin n_err++; $display("FAIL single_count got %0d exp 1", bus.count); end
    n_vec++; if (bus.out_instr !== 32'h25270004) begin n_err++; $display("FAIL single_instr got %h exp 25270004", bus.out_instr); end
    for (int c = 0; c < 5; c++) begin
      if (bus.out_valid === 1'b1) n_issue++;
      tick();
    end
    n_vec++; if (n_issue !== 1) begin n_err++; $display("FAIL single_issues got %0d exp 1", n_issue); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL single_count_end got %0d exp 0", bus.count); end
  endtask

  task automatic test_fill();
    bus.out_ready = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.in_bundle = {mk(32'h100 + 32'(2*b), 2'd0, 1'b1, 1'b0), mk(32'h101 + 32'(2*b), 2'd0, 1'b1, 1'b0)};
      bus.in_valid  = 1'b1;
      #1;
      n_vec++; if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL fill_ready_%0d got %b exp 1", b, bus.in_ready); end
      tick();
    end
    // Bundle still offered while full must be refused.
    bus.in_bundle = {mk(32'hDEAD, 2'd0, 1'b1, 1'b0), mk(32'hBEEF, 2'd0, 1'b1, 1'b0)};
    n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL fill_count got %0d exp 8", bus.count); end
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL fill_full_ready got %b exp 0", bus.in_ready); end
    tick();
    bus.in_valid = 1'b0;
    n_vec++; if (bus.count !== 4'd8) begin n_err++; $display("FAIL fill_hold_count got %0d exp 8", bus.count); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n_vec++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h100 + 32'(k)) begin
        n_err++; $display("FAIL fill_drain_%0d got v=%b %h exp v=1 %h", k, bus.out_valid, bus.out_instr, 32'h100 + 32'(k));
      end
      tick();
    end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL fill_count_end got %0d exp 0", bus.count); end
  endtask

  task automatic test_kill();
    logic [31:0] exp_q [3];
    int idx = 0;
    exp_q[0] = 32'hA0000000; exp_q[1] = 32'hA0000001; exp_q[2] = 32'hC0000000;
    bus.out_ready = 1'b0;
    push({mk(32'hB0000000, 2'd2, 1'b1, 1'b1), mk(32'hA0000000, 2'd1, 1'b1, 1'b1)});
    push({mk(32'hB0000001, 2'd2, 1'b1, 1'b1), mk(32'hA0000001, 2'd1, 1'b1, 1'b1)});
    n_vec++; if (bus.out_instr !== 32'hB0000000 || bus.out_valid !== 1'b1) begin
      n_err++; $display("FAIL kill_head_pre got v=%b %h exp v=1 b0000000", bus.out_valid, bus.out_instr); end
    // Incoming tag2 spec slot is squashed on entry; non-spec tag2 slot survives.
    bus.in_bundle  = {mk(32'hB0000002, 2'd2, 1'b1, 1'b1), mk(32'hC0000000, 2'd2, 1'b1, 1'b0)};
    bus.in_valid   = 1'b1;
    bus.kill_valid = 1'b1;
    bus.kill_tag   = 2'd2;
    #1;
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL kill_head_hit got %b exp 0", bus.out_valid); end
    tick();
    bus.in_valid   = 1'b0;
    bus.kill_valid = 1'b0;
    n_vec++; if (bus.count !== 4'd6) begin n_err++; $display("FAIL kill_count got %0d exp 6", bus.count); end
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid === 1'b1) begin
        n_vec++;
        if (idx > 2 || bus.out_instr !== exp_q[idx > 2 ? 2 : idx]) begin
          n_err++; $display("FAIL kill_issue_%0d got %h exp %h", idx, bus.out_instr, exp_q[idx > 2 ? 2 : idx]);
        end
        idx++;
      end
      tick();
    end
    n_vec++; if (idx !== 3) begin n_err++; $display("FAIL kill_issue_count got %0d exp 3", idx); end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL kill_count_end got %0d exp 0", bus.count); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b0;
    push({mk(32'h500, 2'd0, 1'b1, 1'b0), mk(32'h501, 2'd0, 1'b1, 1'b0)});
    push({mk(32'h502, 2'd0, 1'b1, 1'b0), mk(32'h503, 2'd0, 1'b1, 1'b0)});
    n_vec++; if (bus.count !== 4'd4) begin n_err++; $display("FAIL flush_pre_count got %0d exp 4", bus.count); end
    bus.in_bundle = {mk(32'h504, 2'd0, 1'b1, 1'b0), mk(32'h505, 2'd0, 1'b1, 1'b0)};
    bus.in_valid  = 1'b1;
    bus.flush     = 1'b1;
    #1;
    n_vec++; if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL flush_in_ready got %b exp 0", bus.in_ready); end
    tick();
    bus.flush    = 1'b0;
    bus.in_valid = 1'b0;
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL flush_count got %0d exp 0", bus.count); end
    n_vec++; if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL flush_out_valid got %b exp 0", bus.out_valid); end
    n_vec++; if (bus.out_instr !== 32'h0) begin n_err++; $display("FAIL flush_out_instr got %h exp 0", bus.out_instr); end
    tick();
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL flush_after_count got %0d exp 0", bus.count); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] got [$];
    logic [3:0]  exp_cnt [3];
    logic        exp_rdy [3];
    int          b = 3;
    exp_cnt[0] = 4'd7; exp_cnt[1] = 4'd6; exp_cnt[2] = 4'd7;
    exp_rdy[0] = 1'b1; exp_rdy[1] = 1'b0; exp_rdy[2] = 1'b1;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 3; k++) push({mk(32'h600 + 32'(2*k), 2'd0, 1'b1, 1'b0), mk(32'h601 + 32'(2*k), 2'd0, 1'b1, 1'b0)});
    n_vec++; if (bus.count !== 4'd6) begin n_err++; $display("FAIL b2b_pre_count got %0d exp 6", bus.count); end
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    for (int c = 0; c < 3; c++) begin
      bus.in_bundle = {mk(32'h600 + 32'(2*b), 2'd0, 1'b1, 1'b0), mk(32'h601 + 32'(2*b), 2'd0, 1'b1, 1'b0)};
      #1;
      n_vec++; if (bus.in_ready !== exp_rdy[c]) begin n_err++; $display("FAIL b2b_ready_%0d got %b exp %b", c, bus.in_ready, exp_rdy[c]); end
      if (bus.in_ready === 1'b1) b++;
      if (bus.out_valid === 1'b1) got.push_back(bus.out_instr);
      tick();
      n_vec++; if (bus.count !== exp_cnt[c]) begin n_err++; $display("FAIL b2b_count_%0d got %0d exp %0d", c, bus.count, exp_cnt[c]); end
    end
    bus.in_valid = 1'b0;
    for (int c = 0; c < 12; c++) begin
      if (bus.out_valid === 1'b1) got.push_back(bus.out_instr);
      tick();
    end
    n_vec++; if (got.size() !== 10) begin n_err++; $display("FAIL b2b_issue_count got %0d exp 10", got.size()); end
    for (int k = 0; k < 10 && k < got.size(); k++) begin
      n_vec++; if (got[k] !== 32'h600 + 32'(k)) begin n_err++; $display("FAIL b2b_order_%0d got %h exp %h", k, got[k], 32'h600 + 32'(k)); end
    end
    n_vec++; if (bus.count !== 4'd0) begin n_err++; $display("FAIL b2b_count_end got %0d exp 0", bus.count); end
  endtask

  initial begin
    reset          = 1'b1;
    bus.in_bundle  = '0;
    bus.in_valid   = 1'b0;
    bus.out_ready  = 1'b0;
    bus.kill_valid = 1'b0;
    bus.kill_tag   = 2'd0;
    bus.flush      = 1'b0;
    test_reset();
    test_pair();
    test_single_slot();
    test_fill();
    test_kill();
    test_flush();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
